rr_arbiter_mux: RTL

RR_ARBITER_MUX -- requirements
Module: rr_arbiter_mux

---
 rtl/arb_pkg.sv | 13 +
 rtl/selector_logic_parametrised.sv | 20 ++
 rtl/rr_arbiter_mux.sv | 133 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter/mux slice.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_IN_SIZE  = 2;
  localparam int unsigned DEF_IN_VAL   = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;

endpackage

// File: rtl/selector_logic_parametrised.sv
// AND-OR data selector: returns the slice of in chosen by a one-hot sel, zero when sel is zero.
module selector_logic_parametrised
  import arb_pkg::*;
#(
  parameter int unsigned in_size = DEF_IN_SIZE,
  parameter int unsigned in_val  = DEF_IN_VAL
) (
  input  logic [in_val-1:0]         sel,
  input  logic [in_size*in_val-1:0] in,
  output logic [in_size-1:0]        out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < in_val; i++) begin
      out = out | (in[i*in_size +: in_size] & {in_size{sel[i]}});
    end
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter with registered one-hot grant and combinational data mux.
// Optional per-grant beat limit compiled in with ARB_HOLD_LIMIT_EN.
module rr_arbiter_mux
  import arb_pkg::*;
#(
  parameter int unsigned in_size  = DEF_IN_SIZE,
  parameter int unsigned in_val   = DEF_IN_VAL,
  parameter int unsigned max_hold = DEF_MAX_HOLD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [in_val-1:0]         req,
  input  logic [in_size*in_val-1:0] in,
  input  logic                      out_ready,
  output logic [in_val-1:0]         grant,
  output logic                      out_valid,
  output logic [in_size-1:0]        out
);

  localparam int unsigned PTR_W = $clog2(in_val);

  arb_state_t        state, state_next;
  logic [PTR_W-1:0]  ptr, ptr_next;
  logic [in_val-1:0] grant_next;
  logic [in_val-1:0] cand;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic              take;

  assign out_valid = |(grant & req);

  // Owner is masked out so a hold-limit handover can never re-pick it.
  assign cand = req & ~grant;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= in_val; i++) begin
      idx = (32'(ptr) + i) % in_val;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(max_hold + 1);

  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic             beat;
  logic             hold_expire;

  assign beat        = out_valid & out_ready;
  assign hold_expire = beat && (hold_cnt == CNT_W'(max_hold - 1));
`endif

  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) take = 1'b1;
      end
      OWN: begin
        if (!out_valid) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_expire && win_found) begin
          take = 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
    if (take) begin
      state_next = OWN;
      grant_next = in_val'(1) << win_idx;
      ptr_next   = win_idx;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_comb begin
    hold_cnt_next = hold_cnt;
    if (take || state_next == IDLE || hold_expire) begin
      hold_cnt_next = '0;
    end else if (beat) begin
      hold_cnt_next = hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_next;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= PTR_W'(in_val - 1);
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

  selector_logic_parametrised #(
    .in_size(in_size),
    .in_val (in_val)
  ) u_sel (
    .sel(grant),
    .in (in),
    .out(out)
  );

endmodule
